// File: rtl/vga_cfg_pkg.sv
// Shared definitions for the VGA configuration register file: address map,
// handshake states, field widths and reset colours.
package vga_cfg_pkg;

    localparam int NIBBLE_W = 4;
    localparam int NUM_REGS = 12;
    localparam int COLOR_W  = 12;
    localparam int OFF_W    = 8;

    localparam logic [3:0] ADDR_FG_R    = 4'd0;
    localparam logic [3:0] ADDR_FG_G    = 4'd1;
    localparam logic [3:0] ADDR_FG_B    = 4'd2;
    localparam logic [3:0] ADDR_BG_R    = 4'd3;
    localparam logic [3:0] ADDR_BG_G    = 4'd4;
    localparam logic [3:0] ADDR_BG_B    = 4'd5;
    localparam logic [3:0] ADDR_MODE    = 4'd6;
    localparam logic [3:0] ADDR_PATTERN = 4'd7;
    localparam logic [3:0] ADDR_XOFF_LO = 4'd8;
    localparam logic [3:0] ADDR_XOFF_HI = 4'd9;
    localparam logic [3:0] ADDR_YOFF_LO = 4'd10;
    localparam logic [3:0] ADDR_YOFF_HI = 4'd11;
    localparam logic [3:0] ADDR_RSVD_LO = 4'd12;
    localparam logic [3:0] ADDR_COMMIT  = 4'd15;

    localparam logic [11:0] FG_RESET_DEF = 12'hFFF;
    localparam logic [11:0] BG_RESET_DEF = 12'h000;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    typedef logic [NUM_REGS-1:0][NIBBLE_W-1:0] bank_t;

    // Builds the reset image of a bank: colour nibbles from the reset colours, everything else zero.
    function automatic bank_t reset_bank(input logic [11:0] fg, input logic [11:0] bg);
        bank_t b;
        b = '0;
        b[ADDR_FG_R] = fg[11:8];
        b[ADDR_FG_G] = fg[7:4];
        b[ADDR_FG_B] = fg[3:0];
        b[ADDR_BG_R] = bg[11:8];
        b[ADDR_BG_G] = bg[7:4];
        b[ADDR_BG_B] = bg[3:0];
        return b;
    endfunction

endpackage

// File: rtl/vga_cfg_regfile_shadow_bank.sv
// Shadow register nibbles and their active copies; active takes the whole
// shadow image on copy_en, using the shadow value from before the edge.
module cfg_shadow_bank
    import vga_cfg_pkg::*;
#(
    parameter logic [11:0] FG_RESET = FG_RESET_DEF,
    parameter logic [11:0] BG_RESET = BG_RESET_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [3:0]          wr_idx,
    input  logic [NIBBLE_W-1:0] wr_data,
    input  logic                copy_en,
    output bank_t               active
);

    bank_t shadow_r;
    bank_t active_r;

    // Shadow nibble writes and bulk shadow-to-active copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= reset_bank(FG_RESET, BG_RESET);
            active_r <= reset_bank(FG_RESET, BG_RESET);
        end else begin
            if (copy_en) begin
                active_r <= shadow_r;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wr_idx == 4'(i))) begin
                    shadow_r[i] <= wr_data;
                end
            end
        end
    end

    assign active = active_r;

endmodule

// File: rtl/vga_cfg_regfile.sv
// VGA configuration register file: valid/ack write handshake into a shadow bank,
// committed to the active bank on the next frame_start after a commit request.
module vga_cfg_regfile
    import vga_cfg_pkg::*;
#(
    parameter int          DATA_W      = 4,
    parameter int          ADDR_W      = 4,
    parameter logic [11:0] FG_RESET    = 12'hFFF,
    parameter logic [11:0] BG_RESET    = 12'h000,
    parameter int          AUTO_COMMIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  data,
    input  logic               valid,
    output logic               ack,
    input  logic               frame_start,
    output logic [COLOR_W-1:0] fg_color,
    output logic [COLOR_W-1:0] bg_color,
    output logic [3:0]         mode,
    output logic [3:0]         pattern,
    output logic [OFF_W-1:0]   x_off,
    output logic [OFF_W-1:0]   y_off,
    output logic               commit_pending,
    output logic               err
);

    state_t state_r;
    state_t next_state_s;
    logic   accept_s;
    logic   ack_r;
    logic   commit_pending_r;
    logic   err_r;
    logic   copy_s;
    logic   wr_en_s;
    logic   is_commit_s;
    logic   is_reserved_s;
    bank_t  active_s;

    // Handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: accept once in IDLE, then wait for valid to fall so the
    // decoder's trailing valid cycle is not taken as a second write.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid) begin
                    accept_s     = 1'b1;
                    next_state_s = WAIT_LOW;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_LOW: begin
                if (valid) begin
                    next_state_s = WAIT_LOW;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Address decode of the accepted write.
    always_comb begin
        is_commit_s   = (address == ADDR_W'(ADDR_COMMIT));
        is_reserved_s = (address >= ADDR_W'(ADDR_RSVD_LO)) && (address < ADDR_W'(ADDR_COMMIT));
        wr_en_s       = accept_s && (address < ADDR_W'(NUM_REGS));
        copy_s        = frame_start && commit_pending_r;
    end

    // Ack pulse, commit request and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r            <= 1'b0;
            commit_pending_r <= 1'b0;
            err_r            <= 1'b0;
        end else begin
            ack_r <= accept_s;
            if (accept_s && is_commit_s && data[0]) begin
                err_r <= 1'b0;
            end else if (accept_s && is_reserved_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            // A new request on the copy edge keeps pending set for the next frame.
            if (accept_s && (is_commit_s || (AUTO_COMMIT != 0))) begin
                commit_pending_r <= 1'b1;
            end else if (copy_s) begin
                commit_pending_r <= 1'b0;
            end else begin
                commit_pending_r <= commit_pending_r;
            end
        end
    end

    cfg_shadow_bank #(
        .FG_RESET (FG_RESET),
        .BG_RESET (BG_RESET)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (4'(address)),
        .wr_data (NIBBLE_W'(data)),
        .copy_en (copy_s),
        .active  (active_s)
    );

    assign ack            = ack_r;
    assign commit_pending = commit_pending_r;
    assign err            = err_r;
    assign fg_color       = {active_s[ADDR_FG_R], active_s[ADDR_FG_G], active_s[ADDR_FG_B]};
    assign bg_color       = {active_s[ADDR_BG_R], active_s[ADDR_BG_G], active_s[ADDR_BG_B]};
    assign mode           = active_s[ADDR_MODE];
    assign pattern        = active_s[ADDR_PATTERN];
    assign x_off          = {active_s[ADDR_XOFF_HI], active_s[ADDR_XOFF_LO]};
    assign y_off          = {active_s[ADDR_YOFF_HI], active_s[ADDR_YOFF_LO]};

endmodule

// File: doc/vga_cfg_regfile.md
Name: vga_cfg_regfile

Overview:
- Consumes address/data nibble pairs from the UART frame address decoder.
- Completes a valid/ack handshake with that decoder and writes each nibble into a shadow register bank.
- On an explicit commit command, the shadow bank is copied into the active bank at the next frame boundary, so the VGA timing/pixel stages never see a half-updated configuration mid-frame.
- The active bank drives colour, mode, pattern and offset fields to the pixel generator.

Parameters:
- DATA_W, 4, width of the data nibble per write.
- ADDR_W, 4, width of the register address.
- FG_RESET, 12'hFFF, reset value of foreground colour (shadow and active).
- BG_RESET, 12'h000, reset value of background colour (shadow and active).
- AUTO_COMMIT, 0, when 1 every accepted write also sets commit_pending (no addr 15 needed).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- address  in  ADDR_W  register address from decoder
- data  in  DATA_W  register data from decoder
- valid  in  1  decoder holds high until acked; deasserts one cycle after ack; gives up after 8 cycles
- ack  out  1  single-cycle registered acknowledge
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- fg_color  out  12  active {R,G,B}
- bg_color  out  12  active {R,G,B}
- mode  out  4  active display mode
- pattern  out  4  active test-pattern select
- x_off  out  8  active horizontal offset
- y_off  out  8  active vertical offset
- commit_pending  out  1  commit requested, awaiting frame_start
- err  out  1  sticky; a reserved address was written

Behaviour:
- Reset (rst=0, async): FSM=IDLE; ack=0; commit_pending=0; err=0.
  - Shadow and active: fg=FG_RESET, bg=BG_RESET; mode, pattern, x_off and y_off = 0.
- Address map (write-only):
  - 0/1/2 = fg R/G/B; 3/4/5 = bg R/G/B; 6 = mode; 7 = pattern.
  - 8/9 = x_off[3:0]/[7:4]; 10/11 = y_off[3:0]/[7:4].
  - 12-14 reserved; 15 = commit.
- Handshake FSM:
  - IDLE: valid=1 -> perform write this edge, ack<=1, go WAIT_LOW.
  - WAIT_LOW: ack<=0; stay while valid=1; valid=0 -> IDLE.
  - Ack latency is exactly 1 cycle after valid is first seen high, well inside the decoder's 8-cycle window.
  - The decoder's extra valid-high cycle after ack must not cause a second write; WAIT_LOW guarantees this.
- Write effects:
  - addr 0-11: update the corresponding shadow nibble only.
  - addr 12-14: no register change; err<=1; still acked.
  - addr 15: commit_pending<=1; if data[0]=1 also clear err. The clear has priority over a set in the same cycle (not reachable, one write per cycle).
  - AUTO_COMMIT=1: any accepted write also sets commit_pending.
- Commit:
  - On a frame_start edge with commit_pending=1 (value before the edge): active<=shadow for all fields, commit_pending<=0.
  - With commit_pending=0, frame_start has no effect.
- Simultaneous events:
  - Shadow write and copy on the same edge: the copy uses the pre-write shadow value; the new value waits for a later commit.
  - Commit write (addr 15) and frame_start on the same edge: no copy this frame; pending stays set for the next frame_start.
- Active outputs are registers and change only on a commit copy or reset.
- Reset mid-handshake: FSM returns to IDLE, ack drops immediately.
  - If valid is still high after reset releases, it is treated as a new transaction (written and acked again).
- Two frame_start pulses with no write in between: the second has no effect.

Decomposition:
- Package vga_cfg_pkg:
  - address localparams (ADDR_FG_R ... ADDR_COMMIT)
  - FSM state encoding (IDLE, WAIT_LOW)
  - field widths
  - default reset colours
- Sub-module cfg_shadow_bank: holds the 12 shadow nibbles plus their active copies, with nibble-write enable and bulk-copy enable. The top level keeps the handshake FSM, commit/err logic and output field packing.

Test Plan:
- Reset, then sample outputs -> fg=FFF, bg=000, mode=0, x_off=00, ack=0, commit_pending=0, err=0.
- Writes addr0=A, addr1=5, addr2=3, then addr15 data0; pulse frame_start -> fg stays FFF before the pulse and becomes A53 the cycle after; commit_pending 1 then 0.
- valid held high 2 cycles (decoder-style) with addr6=4 -> exactly one ack pulse, one cycle after valid rises; a second write addr6=7 with no commit -> mode stays 0; after commit + frame_start, mode=7.
- Write addr8=C, addr9=1, commit, with a frame_start pulse on the same edge as the commit write -> x_off unchanged; the next frame_start gives x_off=1C.
- Write addr13=F -> ack pulses, err=1, all fields unchanged; write addr15 data1 -> err=0 and commit_pending=1.
- Assert rst low while in WAIT_LOW with a pending commit -> ack=0, commit_pending=0, all active/shadow fields back to reset values; AUTO_COMMIT=1 build: a single addr7=2 write followed by frame_start gives pattern=2.
